// File: rtl/quick_spi_defs.sv
// quick_spi_defs: constants and state encoding shared by quick_spi and quick_spi_slave
package quick_spi_defs;
    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;
    localparam int LITTLE_ENDIAN = 0;
    localparam int BIG_ENDIAN = 1;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2
    } state_t;
endpackage

// File: rtl/quick_spi_sync.sv
// quick_spi_sync: 2-FF synchroniser with registered rise/fall detection for one asynchronous bit
//   clk  in   system clock
//   d    in   asynchronous input
//   q    out  synchronised level, aligned with rise/fall
//   rise out  one-cycle pulse on a synchronised 0->1
//   fall out  one-cycle pulse on a synchronised 1->0
module quick_spi_sync (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s2;
    // Left unreset so the level seen right after reset reflects the pin.
    always_ff @(posedge clk) begin
        s1   <= d;
        s2   <= s1;
        q    <= s2;
        rise <= s2 & ~q;
        fall <= ~s2 & q;
    end
endmodule

// File: rtl/quick_spi_slave.sv
// quick_spi_slave: oversampling SPI responder, one RX/TX frame per select
//   clk, reset_n        system clock, synchronous active-low reset
//   enable              frame accepted only if high when select falls
//   sclk, ss_n, mosi    asynchronous SPI pins from the initiator
//   miso, miso_oe       serial reply and its pad enable
//   tx_data             reply word, latched at frame start
//   rx_data, rx_valid   received word and its one-cycle update pulse
//   frame_error         one-cycle pulse when a frame ends short
//   busy                high while a frame is being served
module quick_spi_slave
    import quick_spi_defs::*;
#(
    parameter int RX_DATA_WIDTH   = 16,
    parameter int TX_DATA_WIDTH   = 8,
    parameter int BITS_ORDER      = MSB_FIRST,
    parameter bit CPOL            = 1'b0,
    parameter bit CPHA            = 1'b0,
    parameter bit MISO_IDLE_VALUE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     sclk,
    input  logic                     ss_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe,
    input  logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic [RX_DATA_WIDTH-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     frame_error,
    output logic                     busy
);
    localparam int RCW = $clog2(RX_DATA_WIDTH + 1);
    localparam int TCW = $clog2(TX_DATA_WIDTH + 1);

    state_t state, state_nxt;
    logic unused_sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, unused_mosi_rise, unused_mosi_fall;
    logic [RX_DATA_WIDTH-1:0] rx_sr, rx_shift_in;
    logic [TX_DATA_WIDTH-1:0] tx_sr;
    logic [RCW-1:0] rx_count;
    logic [TCW-1:0] tx_count;
    logic lead, trail, sample, shift, active, start, rx_full, rx_last, tx_more;

    quick_spi_sync u_sclk (.clk(clk), .d(sclk), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    quick_spi_sync u_ss   (.clk(clk), .d(ss_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
    quick_spi_sync u_mosi (.clk(clk), .d(mosi), .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    function automatic logic tx_first(input logic [TX_DATA_WIDTH-1:0] x);
        return BITS_ORDER == MSB_FIRST ? x[TX_DATA_WIDTH-1] : x[0];
    endfunction

    function automatic logic [TX_DATA_WIDTH-1:0] tx_next(input logic [TX_DATA_WIDTH-1:0] x);
        return BITS_ORDER == MSB_FIRST ? x << 1 : x >> 1;
    endfunction

    assign lead        = CPOL ? sclk_fall : sclk_rise;
    assign trail       = CPOL ? sclk_rise : sclk_fall;
    assign sample      = CPHA ? trail : lead;
    assign shift       = CPHA ? lead : trail;
    assign active      = state == ACTIVE;
    assign start       = state == IDLE && ss_fall && enable;
    assign rx_full     = rx_count == RCW'(RX_DATA_WIDTH);
    assign rx_last     = sample && rx_count == RCW'(RX_DATA_WIDTH - 1);
    assign tx_more     = tx_count < TCW'(TX_DATA_WIDTH);
    assign rx_shift_in = BITS_ORDER == MSB_FIRST
                       ? (rx_sr << 1) | RX_DATA_WIDTH'(mosi_q)
                       : (rx_sr >> 1) | {mosi_q, {(RX_DATA_WIDTH-1){1'b0}}};

    // A select already low at reset is a frame joined mid-way: ignore it.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ss_q ? IDLE : BLOCKED;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (ss_fall ? (enable ? ACTIVE : BLOCKED) : IDLE)
                                  : (ss_rise ? IDLE : state);
    end

    always_comb begin
        busy    = active;
        miso_oe = active;
    end

    // With CPHA=0 the first bit goes out on entry, so tx_count starts at 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sr       <= '0;
            rx_count    <= '0;
            tx_sr       <= '0;
            tx_count    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            miso        <= MISO_IDLE_VALUE;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            if (start) begin
                rx_count <= '0;
                tx_sr    <= CPHA ? tx_data : tx_next(tx_data);
                tx_count <= CPHA ? TCW'(0) : TCW'(1);
                miso     <= CPHA ? MISO_IDLE_VALUE : tx_first(tx_data);
            end else if (active) begin
                if (sample && !rx_full) begin
                    rx_sr    <= rx_shift_in;
                    rx_count <= rx_count + RCW'(1);
                    if (rx_last) begin
                        rx_data  <= rx_shift_in;
                        rx_valid <= 1'b1;
                    end
                end
                if (shift) begin
                    miso     <= tx_more ? tx_first(tx_sr) : MISO_IDLE_VALUE;
                    tx_sr    <= tx_next(tx_sr);
                    tx_count <= tx_more ? tx_count + TCW'(1) : tx_count;
                end
                // A final sample in the same cycle as the select rise still completes the word.
                if (ss_rise) begin
                    frame_error <= !(rx_full || rx_last);
                    miso        <= MISO_IDLE_VALUE;
                end
            end else begin
                miso <= MISO_IDLE_VALUE;
            end
        end
    end
endmodule

// File: tb/tb_quick_spi_slave.sv
// tb_quick_spi_slave: scoreboard bench for quick_spi_slave in mode 0 MSB-first and mode 3 LSB-first
module tb_quick_spi_slave;
    import quick_spi_defs::*;

    logic clk = 1'b0;
    logic reset_n, enable, mosi;
    logic sclk0, ss_n0, sclk3, ss_n3;
    logic [7:0] tx_data;
    logic miso0, miso_oe0, rx_valid0, frame_error0, busy0;
    logic miso3, miso_oe3, rx_valid3, frame_error3, busy3;
    logic [15:0] rx_data0, rx_data3;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt0 = 0, fecnt0 = 0, vcnt3 = 0;
    bit oe_seen0 = 1'b0;
    logic [15:0] exp0[$];
    logic [15:0] exp3[$];
    logic [15:0] e0, e3;

    always #5 clk = ~clk;

    quick_spi_slave dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk0), .ss_n(ss_n0), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .frame_error(frame_error0), .busy(busy0)
    );

    quick_spi_slave #(.BITS_ORDER(LSB_FIRST), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sclk(sclk3), .ss_n(ss_n3), .mosi(mosi),
        .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data), .rx_data(rx_data3),
        .rx_valid(rx_valid3), .frame_error(frame_error3), .busy(busy3)
    );

    // Scoreboard: every rx_valid pops the word pushed when the frame was driven.
    always @(negedge clk) begin
        if (miso_oe0) oe_seen0 = 1'b1;
        if (frame_error0) fecnt0++;
        if (rx_valid0) begin
            vcnt0++;
            n_cmp++;
            if (exp0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_unexpected: rx_data0=%h arrived, none expected", rx_data0);
            end else begin
                e0 = exp0.pop_front();
                if (rx_data0 !== e0) begin
                    n_err++;
                    $display("FAIL sb0_word: rx_data0=%h expected %h", rx_data0, e0);
                end
            end
        end
        if (rx_valid3) begin
            vcnt3++;
            n_cmp++;
            if (exp3.size() == 0) begin
                n_err++;
                $display("FAIL sb3_unexpected: rx_data3=%h arrived, none expected", rx_data3);
            end else begin
                e3 = exp3.pop_front();
                if (rx_data3 !== e3) begin
                    n_err++;
                    $display("FAIL sb3_word: rx_data3=%h expected %h", rx_data3, e3);
                end
            end
        end
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_ss(input bit m3, input logic v);
        if (m3) ss_n3 = v;
        else    ss_n0 = v;
    endtask

    task automatic spi_begin(input bit m3);
        set_ss(m3, 1'b0);
        half();
    endtask

    task automatic spi_end(input bit m3);
        half();
        set_ss(m3, 1'b1);
        repeat (12) @(negedge clk);
    endtask

    // One SCK period; s is miso as the initiator samples it.
    task automatic spi_bit(input bit m3, input logic b, output logic s);
        if (!m3) begin
            mosi = b;
            half();
            sclk0 = 1'b1;
            s = miso0;
            half();
            sclk0 = 1'b0;
        end else begin
            sclk3 = 1'b0;
            mosi = b;
            half();
            sclk3 = 1'b1;
            s = miso3;
            half();
        end
    endtask

    // wseq holds the first 8 miso bits in wire order, first bit at [7].
    task automatic xfer(input bit m3, input logic [15:0] word, input int nbits, input int extra,
                        output logic [7:0] wseq);
        logic s;
        wseq = '0;
        spi_begin(m3);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(m3, m3 ? word[i] : word[15-i], s);
            if (i < 8) wseq[7-i] = s;
        end
        for (int i = 0; i < extra; i++) spi_bit(m3, 1'b1, s);
        spi_end(m3);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({miso0, miso_oe0, rx_valid0, frame_error0, busy0} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags0: got %b expected 00000", {miso0, miso_oe0, rx_valid0, frame_error0, busy0});
        end
        n_cmp++;
        if ({miso3, miso_oe3, rx_valid3, frame_error3, busy3} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags3: got %b expected 00000", {miso3, miso_oe3, rx_valid3, frame_error3, busy3});
        end
        n_cmp++;
        if (rx_data0 !== 16'h0 || rx_data3 !== 16'h0) begin
            n_err++;
            $display("FAIL reset_rx_data: got %h/%h expected 0000/0000", rx_data0, rx_data3);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] w;
        int v = vcnt0;
        oe_seen0 = 1'b0;
        tx_data = 8'h3C;
        exp0.push_back(16'hA55A);
        xfer(1'b0, 16'hA55A, 16, 0, w);
        n_cmp++;
        if (w !== 8'h3C) begin n_err++; $display("FAIL mode0_miso: read %h expected 3c", w); end
        n_cmp++;
        if (vcnt0 - v != 1 || exp0.size() != 0) begin
            n_err++;
            $display("FAIL mode0_valid: %0d pulses, %0d pending, expected 1 pulse 0 pending", vcnt0 - v, exp0.size());
        end
        n_cmp++;
        if (rx_data0 !== 16'hA55A) begin n_err++; $display("FAIL mode0_rx_data: got %h expected a55a", rx_data0); end
        n_cmp++;
        if ({oe_seen0, miso_oe0, miso0, busy0} !== 4'b1000) begin
            n_err++;
            $display("FAIL mode0_idle: oe_seen/oe/miso/busy=%b expected 1000", {oe_seen0, miso_oe0, miso0, busy0});
        end
    endtask

    task automatic test_mode3();
        logic [7:0] w;
        int v = vcnt3;
        tx_data = 8'hC3;
        exp3.push_back(16'h1234);
        xfer(1'b1, 16'h1234, 16, 0, w);
        n_cmp++;
        if (w !== 8'b11000011) begin n_err++; $display("FAIL mode3_wire: wire bits %b expected 11000011", w); end
        n_cmp++;
        if (vcnt3 - v != 1 || rx_data3 !== 16'h1234) begin
            n_err++;
            $display("FAIL mode3_rx: %0d pulses data %h expected 1 pulse data 1234", vcnt3 - v, rx_data3);
        end
        n_cmp++;
        if ({miso_oe3, miso3} !== 2'b00) begin n_err++; $display("FAIL mode3_idle: oe/miso=%b expected 00", {miso_oe3, miso3}); end
    endtask

    task automatic test_extra_toggles();
        logic [7:0] w;
        int v = vcnt0;
        int f = fecnt0;
        tx_data = 8'h81;
        exp0.push_back(16'h0F0F);
        xfer(1'b0, 16'h0F0F, 16, 3, w);
        n_cmp++;
        if (vcnt0 - v != 1 || fecnt0 - f != 0) begin
            n_err++;
            $display("FAIL extra_pulses: valid %0d error %0d expected 1 and 0", vcnt0 - v, fecnt0 - f);
        end
        n_cmp++;
        if (rx_data0 !== 16'h0F0F) begin n_err++; $display("FAIL extra_rx_data: got %h expected 0f0f", rx_data0); end
        n_cmp++;
        if (w !== 8'h81) begin n_err++; $display("FAIL extra_miso: read %h expected 81", w); end
    endtask

    task automatic test_short_frame();
        logic [7:0] w;
        int v = vcnt0;
        int f = fecnt0;
        xfer(1'b0, 16'h1357, 9, 0, w);
        n_cmp++;
        if (fecnt0 - f != 1 || vcnt0 - v != 0) begin
            n_err++;
            $display("FAIL short_pulses: error %0d valid %0d expected 1 and 0", fecnt0 - f, vcnt0 - v);
        end
        n_cmp++;
        if (rx_data0 !== 16'h0F0F) begin n_err++; $display("FAIL short_hold: got %h expected 0f0f", rx_data0); end
        f = fecnt0;
        exp0.push_back(16'hFFFF);
        xfer(1'b0, 16'hFFFF, 16, 0, w);
        n_cmp++;
        if (rx_data0 !== 16'hFFFF || exp0.size() != 0 || fecnt0 != f) begin
            n_err++;
            $display("FAIL short_next: got %h pending %0d errors %0d expected ffff 0 0", rx_data0, exp0.size(), fecnt0 - f);
        end
    endtask

    task automatic test_enable_blocked();
        logic [7:0] w;
        logic s;
        int v = vcnt0;
        int f = fecnt0;
        oe_seen0 = 1'b0;
        enable = 1'b0;
        spi_begin(1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) enable = 1'b1;
            spi_bit(1'b0, 1'b1, s);
        end
        spi_end(1'b0);
        n_cmp++;
        if (vcnt0 - v != 0 || fecnt0 - f != 0 || oe_seen0) begin
            n_err++;
            $display("FAIL blocked: valid %0d error %0d oe_seen %b expected 0 0 0", vcnt0 - v, fecnt0 - f, oe_seen0);
        end
        tx_data = 8'h5A;
        exp0.push_back(16'h2468);
        xfer(1'b0, 16'h2468, 16, 0, w);
        n_cmp++;
        if (rx_data0 !== 16'h2468 || exp0.size() != 0 || w !== 8'h5A) begin
            n_err++;
            $display("FAIL blocked_next: got %h miso %h pending %0d expected 2468 5a 0", rx_data0, w, exp0.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        logic s;
        int v = vcnt0;
        int f = fecnt0;
        tx_data = 8'hFF;
        spi_begin(1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b1, s);
        n_cmp++;
        if ({busy0, miso_oe0} !== 2'b11) begin n_err++; $display("FAIL midreset_pre: busy/oe=%b expected 11", {busy0, miso_oe0}); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++;
        if ({miso0, miso_oe0, busy0, rx_valid0, frame_error0} !== 5'b0 || rx_data0 !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_outs: flags %b data %h expected 00000 0000",
                     {miso0, miso_oe0, busy0, rx_valid0, frame_error0}, rx_data0);
        end
        for (int i = 5; i < 16; i++) spi_bit(1'b0, 1'b1, s);
        spi_end(1'b0);
        n_cmp++;
        if (vcnt0 - v != 0 || fecnt0 - f != 0 || rx_data0 !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_rest: valid %0d error %0d data %h expected 0 0 0000", vcnt0 - v, fecnt0 - f, rx_data0);
        end
        tx_data = 8'h96;
        exp0.push_back(16'h9ABC);
        xfer(1'b0, 16'h9ABC, 16, 0, w);
        n_cmp++;
        if (rx_data0 !== 16'h9ABC || exp0.size() != 0 || w !== 8'h96) begin
            n_err++;
            $display("FAIL midreset_next: got %h miso %h pending %0d expected 9abc 96 0", rx_data0, w, exp0.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        ss_n0   = 1'b1;
        ss_n3   = 1'b1;
        sclk0   = 1'b0;
        sclk3   = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        test_reset();
        test_mode0();
        test_mode3();
        test_extra_toggles();
        test_short_frame();
        test_enable_blocked();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
